// File: rtl/objects_mux_collision.sv
// Layer-priority pixel mux for bullet/tank/brick/background, plus per-frame
// overlap detection that reports the first bullet-brick hit to the controller.
module objects_mux_collision #(
    parameter int COORD_W   = 11,
    parameter int PIX_DELAY = 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               startOfFrame,
    input  logic               bulletDrawingRequest,
    input  logic [7:0]         bulletRGB,
    input  logic               tankDrawingRequest,
    input  logic [7:0]         tankRGB,
    input  logic               brickDrawingRequest,
    input  logic [7:0]         brickRGB,
    input  logic [7:0]         backGroundRGB,
    input  logic               hitAck,
    output logic [7:0]         RGBOut,
    output logic               bulletBrickCollision,
    output logic               tankBrickCollision,
    output logic               hitValid,
    output logic [COORD_W-1:0] hitX,
    output logic [COORD_W-1:0] hitY
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} hs_state_e;

    logic [PIX_DELAY-1:0][COORD_W-1:0] dX_q, dY_q;
    logic [COORD_W-1:0] dX, dY;
    logic [7:0]         rgb_q, rgb_d;
    logic               bbPulse_q, tbPulse_q;
    logic               bbSeen_q, tbSeen_q;
    logic [COORD_W-1:0] cX_q, cY_q;
    logic [COORD_W-1:0] hitX_q, hitY_q;
    hs_state_e          state_q;
    logic               bb, tb, report;

    assign dX     = dX_q[PIX_DELAY-1];
    assign dY     = dY_q[PIX_DELAY-1];
    assign bb     = bulletDrawingRequest & brickDrawingRequest;
    assign tb     = tankDrawingRequest & brickDrawingRequest;
    assign report = startOfFrame & bbSeen_q;

    // Coordinate delay line so dX/dY line up with the registered bitmap requests.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dX_q <= '0;
            dY_q <= '0;
        end else begin
            dX_q[0] <= pixelX;
            dY_q[0] <= pixelY;
            for (int i = 1; i < PIX_DELAY; i++) begin
                dX_q[i] <= dX_q[i-1];
                dY_q[i] <= dY_q[i-1];
            end
        end
    end

    always_comb begin
        rgb_d = backGroundRGB;
        if (bulletDrawingRequest)     rgb_d = bulletRGB;
        else if (tankDrawingRequest)  rgb_d = tankRGB;
        else if (brickDrawingRequest) rgb_d = brickRGB;
    end

    // A pixel coinciding with startOfFrame belongs to the new frame: the report
    // uses the pre-edge flags and the new flags are seeded from this pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q     <= 8'h00;
            bbPulse_q <= 1'b0;
            tbPulse_q <= 1'b0;
            bbSeen_q  <= 1'b0;
            tbSeen_q  <= 1'b0;
            cX_q      <= '0;
            cY_q      <= '0;
        end else begin
            rgb_q <= rgb_d;
            if (startOfFrame) begin
                bbPulse_q <= bbSeen_q;
                tbPulse_q <= tbSeen_q;
                bbSeen_q  <= bb;
                tbSeen_q  <= tb;
                if (bb) begin
                    cX_q <= dX;
                    cY_q <= dY;
                end
            end else begin
                bbPulse_q <= 1'b0;
                tbPulse_q <= 1'b0;
                bbSeen_q  <= bbSeen_q | bb;
                tbSeen_q  <= tbSeen_q | tb;
                if (bb && !bbSeen_q) begin
                    cX_q <= dX;
                    cY_q <= dY;
                end
            end
        end
    end

    // Hit-report handshake; a new report overrides an unacknowledged one.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            hitX_q  <= '0;
            hitY_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (report) begin
                        state_q <= PENDING;
                        hitX_q  <= cX_q;
                        hitY_q  <= cY_q;
                    end
                end
                PENDING: begin
                    if (report) begin
                        hitX_q <= cX_q;
                        hitY_q <= cY_q;
                    end else if (hitAck) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RGBOut               = rgb_q;
    assign bulletBrickCollision = bbPulse_q;
    assign tankBrickCollision   = tbPulse_q;
    assign hitValid             = (state_q == PENDING);
    assign hitX                 = hitX_q;
    assign hitY                 = hitY_q;

endmodule

// File: doc/objects_mux_collision.md
Name: objects_mux_collision

Overview:
- Consumer end of the bitmap drawing interface. It takes the registered drawingRequest/RGBout pairs from the bullet, tank and brick bitmap blocks and the background colour, and resolves layer priority into a registered RGB pixel for the VGA output stage.
- It also detects per-pixel overlaps (bullet-brick, tank-brick) over each frame. At frame boundary it reports them, and hands the first bullet-brick hit coordinate to the game controller through a valid/ack handshake, so the hit brick can be erased.

Parameters:
COORD_W, 11, width of pixelX/pixelY and hit coordinates
PIX_DELAY, 1, cycles pixelX/pixelY are delayed internally to align with bitmap outputs (range 1-3)

Ports:
clk  in  1  system clock
resetN  in  1  reset; asynchronous, active-low
pixelX  in  COORD_W  current scan X, same cycle the bitmaps receive their offsets
pixelY  in  COORD_W  current scan Y, same timing as pixelX
startOfFrame  in  1  one-cycle pulse at first pixel of a frame
bulletDrawingRequest  in  1  bullet bitmap request (registered by source)
bulletRGB  in  8  bullet colour
tankDrawingRequest  in  1  tank bitmap request
tankRGB  in  8  tank colour
brickDrawingRequest  in  1  brick bitmap request
brickRGB  in  8  brick colour
backGroundRGB  in  8  background colour, aligned with bitmap outputs
hitAck  in  1  controller accepts hit report
RGBOut  out  8  resolved pixel colour
bulletBrickCollision  out  1  one-cycle pulse: bullet overlapped brick in previous frame
tankBrickCollision  out  1  one-cycle pulse: tank overlapped brick in previous frame
hitValid  out  1  hitX/hitY hold a pending bullet-brick report
hitX  out  COORD_W  X of first bullet-brick overlap pixel of reported frame
hitY  out  COORD_W  Y of same pixel

Behaviour:
- Reset (async, resetN=0): RGBOut=8'h00, both collision pulses 0, hitValid 0, hitX=hitY=0, sticky flags and capture registers 0, coordinate delay line 0.
- Alignment: pixelX/pixelY pass through a PIX_DELAY-stage register line (dX/dY); collisions use dX/dY with same-cycle drawing requests.
- Priority (evaluated each cycle, registered into RGBOut, latency 1 cycle from requests): bulletDrawingRequest -> bulletRGB; else tank -> tankRGB; else brick -> brickRGB; else backGroundRGB.
- Per-pixel overlap: bb = bullet&brick requests; tb = tank&brick requests.
- Frame state (sticky, cleared only by startOfFrame or reset):
  - bbSeen set on bb.
  - tbSeen set on tb.
  - On first bb of frame (bbSeen=0), capture cX<=dX, cY<=dY; later bb pixels same frame do not overwrite.
- Frame report on startOfFrame:
  - Next cycle bulletBrickCollision=bbSeen, tankBrickCollision=tbSeen (exactly 1-cycle pulses).
  - If bbSeen: hitX<=cX, hitY<=cY, hitValid<=1 (overwrites a still-pending report; newest wins).
  - Same edge: bbSeen/tbSeen cleared.
- Simultaneous startOfFrame with bb/tb on the same cycle: the coincident pixel belongs to the NEW frame. The report uses pre-edge flags, and the new frame flags/capture are set from this pixel.
- Handshake: hitValid stays 1 until sampled hitAck=1 while hitValid=1 → hitValid 0 next cycle; hitX/hitY hold their values after ack. hitAck with hitValid=0 is ignored. Report and ack on the same edge: report wins, hitValid stays 1.
- Frame with no bb: hitValid/hitX/hitY unchanged, collision pulses 0.
- Reset asserted mid-frame or mid-handshake: all state returns to reset values immediately; the first frame after reset reports only overlaps seen after resetN rises.
- Two-state FSM for the handshake: IDLE (hitValid=0) -> PENDING on report with bbSeen; PENDING -> IDLE on hitAck without report; PENDING -> PENDING on new report.

Test Plan:
- Priority: bullet=1/8'hE0, tank=1/8'h1C, brick=1/8'hA9, bg=8'h00 → RGBOut 8'hE0 one cycle later; drop bullet → 8'h1C; drop tank → 8'hA9; none → 8'h00.
- Single overlap: bb at dX=100,dY=50 mid-frame, then startOfFrame → next cycle bulletBrickCollision=1 for 1 cycle, hitValid=1, hitX=100, hitY=50, tankBrickCollision=0.
- First-hit capture: bb at (100,50) then (200,60) same frame → report hitX=100, hitY=50; ack → hitValid 0, hitX stays 100.
- Coincident edge: bb only on the startOfFrame cycle at (7,3) → no pulse that report; following startOfFrame → pulse, hitX=7, hitY=3.
- Handshake: pending report unacked, new frame with bb at (300,400) → hitValid stays 1, hitX=300; hitAck and report same cycle → hitValid remains 1.
- Reset: tb and bb seen mid-frame, then resetN low 2 cycles → all outputs 0. The next startOfFrame yields no pulses, and RGBOut=0 while held in reset.
